// File: rtl/mux_arb_reg.sv
// N-channel registered multiplexer with valid/ready handshake. The source channel
// comes either from an explicit select code (MODE 0) or from round-robin arbitration (MODE 1).
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NCH*WIDTH-1:0] IN_D,
  input  logic [NCH-1:0]       IN_V,
  output logic [NCH-1:0]       IN_R,
  input  logic [SELW-1:0]      SEL,
  output logic [WIDTH-1:0]     OUT_D,
  output logic                 OUT_V,
  input  logic                 OUT_R,
  output logic [SELW-1:0]      OUT_CH
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic [SELW-1:0]  outCh_q, outCh_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             loadEn;
  logic             selHit;
  logic             grantValid;
  logic [SELW-1:0]  grantIdx;
  logic [WIDTH-1:0] grantData;
  logic [NCH-1:0]   reqRot;
  logic [SELW:0]    candSum;
  logic [SELW-1:0]  ptrNext;

  assign loadEn = !outValid_q || OUT_R;

  // Requests are rotated so bit 0 is the pointer's channel; the lowest set bit wins.
  always_comb begin
    selHit     = 1'b0;
    grantValid = 1'b0;
    grantIdx   = '0;
    candSum    = '0;
    reqRot     = NCH'({IN_V, IN_V} >> ptr_q);
    if (MODE == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (SEL == SELW'(i)) begin
          selHit     = 1'b1;
          grantIdx   = SELW'(i);
          grantValid = IN_V[i];
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (reqRot[k]) begin
          candSum    = {1'b0, ptr_q} + (SELW+1)'(k);
          grantValid = 1'b1;
        end
      end
      if (candSum >= (SELW+1)'(NCH)) begin
        candSum = candSum - (SELW+1)'(NCH);
      end
      grantIdx = candSum[SELW-1:0];
    end
  end

  always_comb begin
    grantData = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grantIdx == SELW'(i)) begin
        grantData = IN_D[i*WIDTH +: WIDTH];
      end
    end
  end

  // In select mode the addressed channel sees ready even when it is not requesting.
  always_comb begin
    IN_R = '0;
    for (int i = 0; i < NCH; i++) begin
      if (MODE == 0) begin
        IN_R[i] = loadEn && selHit && (grantIdx == SELW'(i));
      end else begin
        IN_R[i] = loadEn && grantValid && (grantIdx == SELW'(i));
      end
    end
  end

  assign ptrNext = (grantIdx == SELW'(NCH - 1)) ? '0 : grantIdx + SELW'(1);

  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outCh_d    = outCh_q;
    ptr_d      = ptr_q;
    if (loadEn) begin
      if (grantValid) begin
        outData_d  = grantData;
        outCh_d    = grantIdx;
        outValid_d = 1'b1;
        if (MODE != 0) begin
          ptr_d = ptrNext;
        end
      end else begin
        outValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outCh_q    <= '0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outCh_q    <= outCh_d;
      ptr_q      <= ptr_d;
    end
  end

  assign OUT_D  = outData_q;
  assign OUT_V  = outValid_q;
  assign OUT_CH = outCh_q;

endmodule
